// File: rtl/param_adder_accum.sv
// param_adder_accum: registered unsigned add / subtract / accumulate unit.
// It has valid/ready handshakes on the input and output sides and a running
// accumulator with an op counter.
// Build option: define SATURATE_EN to clamp results instead of wrapping.
// ADD and ACC clamp to all-ones; SUB clamps to zero. The carry output still
// flags the overflow or borrow.
// Mode encoding: 00 ADD | 01 SUB | 10 ACC | 11 CLR

module param_adder_accum #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic [CNT_W-1:0] acc_count
);

    typedef enum logic [1:0] {
        MODE_ADD = 2'b00,
        MODE_SUB = 2'b01,
        MODE_ACC = 2'b10,
        MODE_CLR = 2'b11
    } mode_t;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_carry;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_acc_count;

    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_sub;
    logic [WIDTH:0]   w_acc;
    logic [WIDTH-1:0] w_add_res;
    logic [WIDTH-1:0] w_sub_res;
    logic [WIDTH-1:0] w_acc_res;
    logic [WIDTH-1:0] w_res_next;
    logic             w_carry_next;
    logic             w_accept;

    // The new beat may replace the old result in the same cycle that the old result is popped.
    assign in_ready  = ~r_out_valid | out_ready;
    assign w_accept  = in_valid & in_ready;

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign carry     = r_carry;
    assign acc_count = r_acc_count;

    // The top bit of each extended sum is the carry; the top bit of the extended difference is the borrow.
    assign w_add = {1'b0, op_a} + {1'b0, op_b};
    assign w_sub = {1'b0, op_a} - {1'b0, op_b};
    assign w_acc = {1'b0, r_acc} + {1'b0, op_a};

`ifdef SATURATE_EN
    assign w_add_res = w_add[WIDTH] ? {WIDTH{1'b1}} : w_add[WIDTH-1:0];
    assign w_sub_res = w_sub[WIDTH] ? {WIDTH{1'b0}} : w_sub[WIDTH-1:0];
    assign w_acc_res = w_acc[WIDTH] ? {WIDTH{1'b1}} : w_acc[WIDTH-1:0];
`else
    assign w_add_res = w_add[WIDTH-1:0];
    assign w_sub_res = w_sub[WIDTH-1:0];
    assign w_acc_res = w_acc[WIDTH-1:0];
`endif

    // Select the result and carry for the beat being presented.
    always_comb begin
        w_res_next   = '0;
        w_carry_next = 1'b0;
        case (mode_t'(mode))
            MODE_ADD: begin
                w_res_next   = w_add_res;
                w_carry_next = w_add[WIDTH];
            end
            MODE_SUB: begin
                w_res_next   = w_sub_res;
                w_carry_next = w_sub[WIDTH];
            end
            MODE_ACC: begin
                w_res_next   = w_acc_res;
                w_carry_next = w_acc[WIDTH];
            end
            default: begin
                w_res_next   = '0;
                w_carry_next = 1'b0;
            end
        endcase
    end

    // Load the output register when a beat is accepted; the accumulator and counter change only then.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_carry     <= 1'b0;
            r_acc       <= '0;
            r_acc_count <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_result    <= w_res_next;
            r_carry     <= w_carry_next;
            if (mode_t'(mode) == MODE_ACC) begin
                r_acc       <= w_acc_res;
                r_acc_count <= r_acc_count + CNT_W'(1);
            end else if (mode_t'(mode) == MODE_CLR) begin
                r_acc       <= '0;
                r_acc_count <= '0;
            end
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_param_adder_accum.sv
// Self-checking bench for param_adder_accum (WIDTH=4, CNT_W=4).
// The reference model predicts each accepted beat and pushes the prediction into a queue.
// A monitor compares the DUT output register against the head of that queue.
// Build option: SATURATE_EN must match the RTL build.

module tb_param_adder_accum;

    localparam int WIDTH = 4;
    localparam int CNT_W = 4;
    localparam int MAXV  = (1 << WIDTH) - 1;
    localparam int CMOD  = 1 << CNT_W;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [1:0]       mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic [CNT_W-1:0] acc_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int res;
        int c;
        int cnt;
    } exp_t;

    exp_t q[$];

    // Reference model state
    int  m_acc = 0;
    int  m_cnt = 0;
    bit  exp_ov = 1'b0;

    param_adder_accum #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .acc_count (acc_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int clampv(input int v);
`ifdef SATURATE_EN
        return (v > MAXV) ? MAXV : v;
`else
        return v % (MAXV + 1);
`endif
    endfunction

    // Predict one accepted beat from the arithmetic rules and update the model.
    function automatic exp_t predict(input int m, input int a, input int b);
        exp_t e;
        int   s;
        case (m)
            0: begin
                s = a + b;
                e.c = (s > MAXV) ? 1 : 0;
                e.res = clampv(s);
            end
            1: begin
                e.c = (a < b) ? 1 : 0;
`ifdef SATURATE_EN
                e.res = (a < b) ? 0 : a - b;
`else
                e.res = (a - b + MAXV + 1) % (MAXV + 1);
`endif
            end
            2: begin
                s = m_acc + a;
                e.c = (s > MAXV) ? 1 : 0;
                e.res = clampv(s);
                m_acc = e.res;
                m_cnt = (m_cnt + 1) % CMOD;
            end
            default: begin
                m_acc = 0;
                m_cnt = 0;
                e.res = 0;
                e.c = 0;
            end
        endcase
        e.cnt = m_cnt;
        return e;
    endfunction

    // Drive one cycle of stimulus and check the handshake outputs.
    task automatic beat(input bit v, input int m, input int a, input int b, input bit ordy);
        bit acc_ok;
        @(negedge clk);
        #1;
        in_valid  = v;
        mode      = m[1:0];
        op_a      = a[WIDTH-1:0];
        op_b      = b[WIDTH-1:0];
        out_ready = ordy;
        #1;
        chk("out_valid", int'(out_valid), int'(exp_ov));
        chk("in_ready", int'(in_ready), int'(!exp_ov || ordy));
        acc_ok = v && (!exp_ov || ordy);
        if (acc_ok) q.push_back(predict(m, a, b));
        if (acc_ok) exp_ov = 1'b1;
        else if (ordy) exp_ov = 1'b0;
    endtask

    // Monitor: a stalled result must equal the queue head, and a popped result consumes the head.
    always begin
        @(negedge clk);
        #3;
        if (!reset && out_valid) begin
            if (q.size() == 0) begin
                chk("queue_nonempty", 0, 1);
            end else begin
                chk("result", int'(result), q[0].res);
                chk("carry", int'(carry), q[0].c);
                chk("acc_count", int'(acc_count), q[0].cnt);
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        op_a      = '0;
        op_b      = '0;
        mode      = 2'b00;
        out_ready = 1'b1;
        #12;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_carry", int'(carry), 0);
        chk("rst_acc_count", int'(acc_count), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        @(negedge clk);
        reset = 1'b0;

        // Add, subtract, then accumulate three times and clear.
        beat(1, 0, 9, 8, 1);
        beat(0, 0, 0, 0, 1);
        beat(0, 0, 0, 0, 1);
        beat(1, 1, 3, 5, 1);
        beat(1, 1, 7, 2, 1);
        beat(1, 2, 6, 9, 1);
        beat(1, 2, 6, 9, 1);
        beat(1, 2, 6, 9, 1);
        beat(1, 3, 5, 5, 1);
        beat(0, 0, 0, 0, 1);

        // Backpressure: the result is held, an extra beat is ignored, then pop and accept happen together.
        beat(1, 0, 1, 2, 0);
        beat(1, 0, 9, 9, 0);
        beat(1, 2, 5, 0, 0);
        beat(1, 0, 4, 4, 1);
        beat(0, 0, 0, 0, 1);

        // Reset asserted while a result is pending aborts it without a clock edge.
        beat(1, 3, 0, 0, 1);
        beat(1, 2, 6, 0, 1);
        beat(1, 2, 6, 0, 1);
        beat(0, 0, 0, 0, 0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_out_valid", int'(out_valid), 0);
        chk("async_rst_acc_count", int'(acc_count), 0);
        chk("async_rst_in_ready", int'(in_ready), 1);
        q.delete();
        m_acc  = 0;
        m_cnt  = 0;
        exp_ov = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        beat(1, 2, 1, 0, 1);
        beat(0, 0, 0, 0, 1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            beat(bit'($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, MAXV)), int'($urandom_range(0, MAXV)),
                 bit'($urandom_range(0, 3) != 0));
        end

        // Accumulate past the counter wrap.
        for (int i = 0; i < CMOD + 2; i++) beat(1, 2, int'($urandom_range(0, MAXV)), 0, 1);

        for (int i = 0; i < 4; i++) beat(0, 0, 0, 0, 1);
        #4;
        chk("queue_drained", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
